// File: rtl/pixel_streamer.sv
// pixel_streamer
//   Transmit side of the convolution pixel stream. On start it reads an IMG_W x IMG_H
//   image from a synchronous RAM in raster order and emits one pixel per beat on a
//   valid/ready stream. Frame (sof) and line (eol) markers travel with each beat, and a
//   2-entry skid FIFO absorbs downstream stalls without losing or repeating pixels.
//
// Optional build macro:
//   FLUSH_PAD_EN  when defined, PAD_LEN zero-valued beats with out_pad=1 follow the last
//                 image pixel to push the tail through the downstream delay line. When
//                 undefined, the PAD state does not exist and out_pad is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any frame, no done pulse)
//   start        begin a frame; only looked at in IDLE
//   busy         high while a frame is in progress (READ/DRAIN/PAD/DONE)
//   done         one-cycle pulse the cycle after the final beat is accepted
//   mem_addr     RAM read address, row*IMG_W+col
//   mem_rd_en    RAM read strobe; mem_rd_data is valid exactly one cycle later
//   mem_rd_data  RAM read data
//   out_data     pixel (0 when no beat is presented)
//   out_valid    beat valid
//   out_ready    downstream accept; a beat transfers when out_valid && out_ready
//   out_sof      marks pixel (0,0)
//   out_eol      marks column IMG_W-1 of every row
//   out_pad      marks a flush beat
module pixel_streamer #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int DW      = 16,
  parameter int AW      = 10,
  parameter int PAD_LEN = 58
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_pad
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef FLUSH_PAD_EN
  localparam logic [2:0] S_PAD   = 3'd3;
  localparam int         PW      = (PAD_LEN > 1) ? $clog2(PAD_LEN) : 1;
`endif

  // Elaboration-time sanity check on the configuration.
  if (((2 ** AW) < NPIX) || (PAD_LEN < 1)) begin : g_param_check
    $error("pixel_streamer: AW too small for IMG_W*IMG_H, or PAD_LEN < 1");
  end

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] rd_addr;
  logic          vld_p1;         // read issued last cycle, data on mem_rd_data now
  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_count;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic          start_acc;
  logic          fifo_nonempty;
  logic          fifo_pop;
  logic [2:0]    occ;
  logic          issue_ok;
  logic          last_issue;
  logic          drain_clear;

  assign start_acc     = (state == S_IDLE) && start;
  assign fifo_nonempty = (fifo_count != 2'd0);
  assign fifo_pop      = fifo_nonempty && out_ready;

  // Occupancy counts both stored entries and the read still in the RAM pipeline, so a
  // read is only issued when its data is guaranteed a free slot on return.
  assign occ         = {1'b0, fifo_count} + {2'b00, vld_p1};
  assign issue_ok    = (occ - {2'b00, fifo_pop}) < 3'd2;
  assign mem_rd_en   = (state == S_READ) && issue_ok;
  assign mem_addr    = rd_addr;
  assign last_issue  = mem_rd_en && (rd_addr == LAST_ADDR);

  // Leave DRAIN in the same cycle the last stored beat is accepted, so done lands on
  // the very next cycle.
  assign drain_clear = !vld_p1 &&
                       ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && fifo_pop));

`ifdef FLUSH_PAD_EN
  logic [PW-1:0] pad_cnt;
  logic          pad_active;
  logic          pad_pop;
  logic          pad_last;

  assign pad_active = (state == S_PAD);
  assign pad_pop    = pad_active && out_ready;
  assign pad_last   = (pad_cnt == PW'(PAD_LEN - 1));
  assign out_valid  = fifo_nonempty || pad_active;
  assign out_pad    = pad_active;
`else
  assign out_valid  = fifo_nonempty;
  assign out_pad    = 1'b0;
`endif

  // Outputs are decoded from registered FIFO/counter state only, so they hold steady
  // across any stall.
  assign out_data = fifo_nonempty ? fifo_mem[rd_ptr] : '0;
  assign out_sof  = fifo_nonempty && (col == '0) && (row == '0);
  assign out_eol  = fifo_nonempty && (col == COL_LAST);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (last_issue) state_nxt = S_DRAIN;
`ifdef FLUSH_PAD_EN
      S_DRAIN: if (drain_clear) state_nxt = S_PAD;
      S_PAD:   if (pad_pop && pad_last) state_nxt = S_DONE;
`else
      S_DRAIN: if (drain_clear) state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: issue read, track it in flight, FIFO/marker bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_addr    <= '0;
      vld_p1     <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      col        <= '0;
      row        <= '0;
    end else begin
      assert (!(vld_p1 && (fifo_count == 2'd2)));
      state  <= state_nxt;
      vld_p1 <= mem_rd_en;

      if (start_acc) begin
        rd_addr <= '0;
      end else if (mem_rd_en) begin
        rd_addr <= last_issue ? '0 : rd_addr + 1'b1;
      end

      if (vld_p1)   wr_ptr <= ~wr_ptr;
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(vld_p1) - 2'(fifo_pop);

      if (start_acc) begin
        col <= '0;
        row <= '0;
      end else if (fifo_pop) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stage p1 -> FIFO: capture returned RAM data
  always_ff @(posedge clk) begin
    if (vld_p1) fifo_mem[wr_ptr] <= mem_rd_data;
  end

`ifdef FLUSH_PAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_cnt <= '0;
    end else if (state == S_DRAIN) begin
      pad_cnt <= '0;
    end else if (pad_pop) begin
      pad_cnt <= pad_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer
//   Directed bench for pixel_streamer (28x28 image, RAM[a] = a). Covers reset and
//   reset-abort, a full frame at full throughput, periodic and long backpressure, a
//   start pulse while busy, and flush padding when FLUSH_PAD_EN is defined.
module tb_pixel_streamer;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int DW      = 16;
  localparam int AW      = 10;
  localparam int PAD_LEN = 58;
  localparam int NPIX    = IMG_W * IMG_H;
`ifdef FLUSH_PAD_EN
  localparam int NPAD    = PAD_LEN;
`else
  localparam int NPAD    = 0;
`endif
  localparam int BUDGET  = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;
  logic          out_pad;

  int n_assert = 0;
  int n_fail   = 0;

  pixel_streamer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW), .PAD_LEN(PAD_LEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_pad(out_pad)
  );

  always #5 clk = ~clk;

  // Synchronous RAM holding RAM[a] = a, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= DW'(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sof"},   out_sof,   0);
    check({tag, "_out_eol"},   out_eol,   0);
    check({tag, "_out_pad"},   out_pad,   0);
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating;
  // mode 2: ready held 0 for 20 cycles once beat 10 is presented.
  // restart: pulse start again while beat 100 is presented.
  task automatic run_frame(input string tag, input int mode, input bit restart);
    int            k;
    int            accepted;
    int            issued;
    int            k_last;
    int            stall_left;
    int            occ;
    int            total;
    bit            pop;
    bit            exp_rd;
    bit            exp_done;
    bit            prev_stall;
    bit            stalled_once;
    bit            restarted;
    bit            done_seen;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] prev_data;
    logic          prev_sof;
    logic          prev_eol;

    total        = NPIX + NPAD;
    accepted     = 0;
    issued       = 0;
    k_last       = -10;
    stall_left   = 0;
    prev_stall   = 1'b0;
    stalled_once = 1'b0;
    restarted    = 1'b0;
    done_seen    = 1'b0;
    prev_data    = '0;
    prev_sof     = 1'b0;
    prev_eol     = 1'b0;

    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;

    for (k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && !restarted && accepted == 100) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      case (mode)
        1: out_ready = ((k % 4) == 1) || ((k % 4) == 0);
        2: begin
          if (!stalled_once && accepted == 10) begin
            stall_left   = 20;
            stalled_once = 1'b1;
          end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: out_ready = 1'b1;
      endcase
      #1;

      pop    = out_valid && out_ready;
      occ    = issued - accepted;
      exp_rd = (issued < NPIX) && ((occ - int'(pop)) < 2);
      check({tag, "_rd_en"}, mem_rd_en, exp_rd);
      if (mem_rd_en) begin
        check({tag, "_mem_addr"}, mem_addr, issued);
        issued++;
      end

      if (prev_stall) begin
        check({tag, "_stall_valid"}, out_valid, 1);
        check({tag, "_stall_data"},  out_data,  prev_data);
        check({tag, "_stall_sof"},   out_sof,   prev_sof);
        check({tag, "_stall_eol"},   out_eol,   prev_eol);
      end

      if (out_valid) begin
        if (mode == 0 && accepted == 0) check({tag, "_first_valid_cycle"}, k, 3);
        exp_data = (accepted < NPIX) ? DW'(accepted) : '0;
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_sof"},  out_sof,  accepted == 0);
        check({tag, "_eol"},  out_eol,  (accepted < NPIX) && ((accepted % IMG_W) == IMG_W - 1));
        check({tag, "_pad"},  out_pad,  accepted >= NPIX);
        check({tag, "_overrun"}, accepted < total, 1);
      end

      exp_done = (accepted == total) && (k == k_last + 1);
      check({tag, "_done"}, done, exp_done);
      check({tag, "_busy"}, busy, 1);

      if (pop) begin
        accepted++;
        k_last = k;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sof   = out_sof;
      prev_eol   = out_eol;

      if (done) begin
        done_seen = 1'b1;
        break;
      end
    end

    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_beats"},     accepted,  total);
    check({tag, "_reads"},     issued,    NPIX);

    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check({tag, "_idle_busy"},  busy,      0);
      check({tag, "_idle_valid"}, out_valid, 0);
      check({tag, "_idle_done"},  done,      0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;

    // T1: reset state, then abort a frame with reset.
    repeat (2) @(negedge clk);
    check_quiet("t1_reset");
    rst = 1'b0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_busy_after_start", busy, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("t1_abort");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_no_done", done, 0);
      check("t1_no_busy", busy, 0);
    end

    // T2 / T6: full frame with out_ready held high.
    run_frame("t2_full", 0, 1'b0);
    // T3: periodic backpressure.
    run_frame("t3_toggle", 1, 1'b0);
    // T4: long stall at beat 10.
    run_frame("t4_stall", 2, 1'b0);
    // T5: start pulse while busy is ignored.
    run_frame("t5_restart", 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
